// File: rtl/sonar_altitude_pkg.sv
// sonar_altitude_pkg: shared definitions for the sonar ranging front end.
// Holds the FSM encoding, counter widths and the echo-time to millimetre
// conversion (us * 11239 >> 16, about 0.1715 mm/us).
package sonar_altitude_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_CONVERT   = 3'd4,
        ST_EMIT      = 3'd5
    } state_t;

    localparam int DATA_W      = 16;  // altitude sample width
    localparam int PERIOD_W    = 16;  // trigger period counter width
    localparam int US_W        = 15;  // microsecond counter width
    localparam int SCALE_W     = 14;  // width of the scale constant
    localparam int SCALE_SHIFT = 16;
    localparam int MM_W        = US_W + SCALE_W - SCALE_SHIFT;

    localparam logic [SCALE_W-1:0] MM_SCALE = 14'd11239;

    // Echo width in us to distance in mm, clamped to max_mm.
    function automatic logic [DATA_W-1:0] us_to_mm(input logic [US_W-1:0] us,
                                                   input int max_mm);
        logic [US_W+SCALE_W-1:0] prod;
        logic [MM_W-1:0]         mm;
        prod = {{SCALE_W{1'b0}}, us} * {{US_W{1'b0}}, MM_SCALE};
        mm   = MM_W'(prod >> SCALE_SHIFT);
        if (DATA_W'(mm) > DATA_W'(max_mm))
            return DATA_W'(max_mm);
        return DATA_W'(mm);
    endfunction

endpackage

// File: rtl/sonar_median3.sv
// sonar_median3: median-of-3 spike filter for altitude samples.
// Built only when SONAR_MEDIAN_EN is defined. The incoming sample is the
// newest of the three taps; two registers hold the older ones. The median
// is registered, adding one cycle to the strobe path. History resets to 0.
`ifdef SONAR_MEDIAN_EN
module sonar_median3
    import sonar_altitude_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] hist0, hist1;
    logic [DATA_W-1:0] med;

    // Comparator network selecting the middle of the three taps
    always_comb begin
        med = in_data;
        if (in_data > hist0) begin
            if (hist0 > hist1)        med = hist0;
            else if (in_data > hist1) med = hist1;
            else                      med = in_data;
        end else begin
            if (in_data > hist1)      med = in_data;
            else if (hist0 > hist1)   med = hist1;
            else                      med = hist0;
        end
    end

    // Shift the history and register the median on each new sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist0     <= '0;
            hist1     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                hist1    <= hist0;
                hist0    <= in_data;
                out_data <= med;
            end
        end
    end

endmodule
`endif

// File: rtl/sonar_altitude.sv
// sonar_altitude: HC-SR04 style ranging front end. Fires a periodic trigger,
// times the echo at 1 us resolution, converts to mm, clamps to MAX_ALT_MM and
// emits a one-cycle valid strobe (with a timeout flag for substitute samples).
// Optional feature macro: SONAR_MEDIAN_EN adds a median-of-3 filter on the
// output path (one extra cycle of latency).
module sonar_altitude
    import sonar_altitude_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 12_000_000,
    parameter int TRIG_US      = 10,
    parameter int PERIOD_US    = 60000,
    parameter int ECHO_WAIT_US = 5000,
    parameter int ECHO_MAX_US  = 30000,
    parameter int MAX_ALT_MM   = 5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               echo,
    output logic               trigger,
    output logic signed [15:0] source_data,
    output logic               source_data_valid,
    output logic               source_timeout
);

    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic                echo_s1, echo_s2, echo_d;
    logic                echo_rise, echo_fall;
    logic [PW-1:0]       presc;
    logic                tick;
    logic                enter_trig;
    logic                started;
    logic [PERIOD_W-1:0] period_cnt;
    logic [US_W-1:0]     us_cnt;
    state_t              state;
    logic [DATA_W-1:0]   sample;
    logic                sample_to;
    logic                emit_valid;
    logic [DATA_W-1:0]   emit_data;
    logic                emit_to;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    assign echo_rise = echo_s2 & ~echo_d;
    assign echo_fall = ~echo_s2 & echo_d;

    // First trigger fires on the first tick after reset, later ones once a
    // full period of ticks has elapsed since the previous TRIG entry.
    assign tick       = (presc == PW'(DIV - 1));
    assign enter_trig = (state == ST_IDLE) && tick &&
                        (!started || period_cnt >= PERIOD_W'(PERIOD_US - 1));

    // Microsecond prescaler, realigned at TRIG entry so trigger width is exact
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           presc <= '0;
        else if (enter_trig) presc <= '0;
        else if (tick)       presc <= '0;
        else                 presc <= presc + PW'(1);
    end

    // Ticks elapsed since the last TRIG entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           period_cnt <= '0;
        else if (enter_trig) period_cnt <= '0;
        else if (tick)       period_cnt <= period_cnt + PERIOD_W'(1);
    end

    // Ranging FSM with registered trigger and output strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            started    <= 1'b0;
            us_cnt     <= '0;
            trigger    <= 1'b0;
            sample     <= '0;
            sample_to  <= 1'b0;
            emit_valid <= 1'b0;
            emit_data  <= '0;
            emit_to    <= 1'b0;
        end else begin
            emit_valid <= 1'b0;
            emit_to    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enter_trig) begin
                        state   <= ST_TRIG;
                        trigger <= 1'b1;
                        started <= 1'b1;
                        us_cnt  <= '0;
                    end
                end
                ST_TRIG: begin
                    if (tick) begin
                        if (us_cnt == US_W'(TRIG_US - 1)) begin
                            state   <= ST_WAIT_ECHO;
                            trigger <= 1'b0;
                            us_cnt  <= '0;
                        end else begin
                            us_cnt <= us_cnt + US_W'(1);
                        end
                    end
                end
                ST_WAIT_ECHO: begin
                    if (echo_rise) begin
                        state  <= ST_MEASURE;
                        us_cnt <= '0;
                    end else if (tick) begin
                        if (us_cnt == US_W'(ECHO_WAIT_US - 1)) begin
                            state     <= ST_EMIT;
                            sample    <= DATA_W'(MAX_ALT_MM);
                            sample_to <= 1'b1;
                        end else begin
                            us_cnt <= us_cnt + US_W'(1);
                        end
                    end
                end
                ST_MEASURE: begin
                    // Count the tick even in the fall cycle so the count
                    // equals the echo width in whole microseconds.
                    if (tick)
                        us_cnt <= us_cnt + US_W'(1);
                    if (echo_fall) begin
                        state <= ST_CONVERT;
                    end else if (tick && us_cnt == US_W'(ECHO_MAX_US - 1)) begin
                        state     <= ST_EMIT;
                        sample    <= DATA_W'(MAX_ALT_MM);
                        sample_to <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    sample    <= us_to_mm(us_cnt, MAX_ALT_MM);
                    sample_to <= 1'b0;
                    state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    emit_valid <= 1'b1;
                    emit_data  <= sample;
                    emit_to    <= sample_to;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SONAR_MEDIAN_EN
    logic [DATA_W-1:0] med_data;
    logic              med_valid;
    logic              to_d;

    // Timeout flag follows the newest sample, delayed to match the filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_d <= 1'b0;
        else       to_d <= emit_to;
    end

    sonar_median3 u_median (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (emit_valid),
        .in_data   (emit_data),
        .out_valid (med_valid),
        .out_data  (med_data)
    );

    assign source_data       = $signed(med_data);
    assign source_data_valid = med_valid;
    assign source_timeout    = to_d;
`else
    assign source_data       = $signed(emit_data);
    assign source_data_valid = emit_valid;
    assign source_timeout    = emit_to;
`endif

endmodule

// File: tb/tb_sonar_altitude.sv
// tb_sonar_altitude: directed scoreboard bench for sonar_altitude.
// Runs at 2 MHz with shortened period/wait/max times so the whole run stays
// small; expected millimetre values are hand computed from us*11239>>16.
`timescale 1ns/1ps
module tb_sonar_altitude;

    localparam int CLK_HZ    = 2_000_000;
    localparam int DIV       = 2;
    localparam int TRIG_US   = 10;
    localparam int PERIOD_US = 7000;
    localparam int WAIT_US   = 500;
    localparam int EMAX_US   = 6000;
    localparam int MAX_MM    = 1000;
`ifdef SONAR_MEDIAN_EN
    localparam int XLAT = 1;
`else
    localparam int XLAT = 0;
`endif

    typedef struct {
        int mm;
        bit to;
        int id;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               echo = 1'b0;
    logic               trigger;
    logic signed [15:0] source_data;
    logic               source_data_valid;
    logic               source_timeout;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   n_strobe = 0;
    int   cyc = 0;
`ifdef SONAR_MEDIAN_EN
    int   h0 = 0;
    int   h1 = 0;
`endif

    sonar_altitude #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .TRIG_US      (TRIG_US),
        .PERIOD_US    (PERIOD_US),
        .ECHO_WAIT_US (WAIT_US),
        .ECHO_MAX_US  (EMAX_US),
        .MAX_ALT_MM   (MAX_MM)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .echo              (echo),
        .trigger           (trigger),
        .source_data       (source_data),
        .source_data_valid (source_data_valid),
        .source_timeout    (source_timeout)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic int med3(input int a, input int b, input int c);
        int t;
        if (a > b) begin t = a; a = b; b = t; end
        if (b > c) begin t = b; b = c; c = t; end
        if (a > b) begin t = a; a = b; b = t; end
        return b;
    endfunction

    task automatic push_exp(input int mm, input bit to);
        exp_t e;
`ifdef SONAR_MEDIAN_EN
        e.mm = med3(mm, h0, h1);
        h1 = h0;
        h0 = mm;
`else
        e.mm = mm;
`endif
        e.to = to;
        e.id = n_push;
        n_push++;
        exp_q.push_back(e);
    endtask

    task automatic clear_hist();
`ifdef SONAR_MEDIAN_EN
        h0 = 0;
        h1 = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        echo  = 1'b0;
        clear_hist();
        repeat (3) @(negedge clk);
        check("rst_trigger", int'(trigger), 0);
        check("rst_data", int'(source_data), 0);
        check("rst_valid", int'(source_data_valid), 0);
        check("rst_timeout", int'(source_timeout), 0);
        reset = 1'b0;
    endtask

    // Wait for trigger to rise, then measure its width; ends on the first
    // negedge with trigger low.
    task automatic trig_cycle(input int bound, output int waited, output int t_rise);
        int w;
        waited = 0;
        while (trigger !== 1'b1 && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        t_rise = cyc;
        if (trigger !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL trig_rise: got no trigger within %0d cycles, want a trigger", bound);
        end else begin
            w = 0;
            while (trigger === 1'b1 && w < 4 * TRIG_US * DIV) begin
                @(negedge clk);
                w++;
            end
            check("trig_width", w, TRIG_US * DIV);
        end
    endtask

    // Echo pulse of w_us, starting 100 us after the trigger falls.
    task automatic echo_pulse(input int w_us, input int mm);
        repeat (100 * DIV) @(negedge clk);
        echo = 1'b1;
        repeat (w_us * DIV) @(negedge clk);
        echo = 1'b0;
        push_exp(mm, 1'b0);
        repeat (4 + XLAT) @(negedge clk);
        check("lat_early", int'(source_data_valid), 0);
        @(negedge clk);
        check("lat_strobe", int'(source_data_valid), 1);
    endtask

    // Scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (source_data_valid === 1'b1) begin
            n_strobe++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe_unexpected: got data=%0d timeout=%0b, want no strobe",
                         source_data, source_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(source_data) != mon_e.mm || source_timeout !== mon_e.to) begin
                    n_err++;
                    $display("FAIL sample_%0d: got data=%0d timeout=%0b, want data=%0d timeout=%0b",
                             mon_e.id, source_data, source_timeout, mon_e.mm, mon_e.to);
                end
            end
        end
    end

    initial begin
        int waited, t1, t2, t3, s;

        // Reset state, trigger on first tick, async drop of trigger mid-TRIG
        do_reset();
        trig_cycle(10 * DIV, waited, t1);
        do_reset();
        trig_cycle(10 * DIV, waited, t1);
        check("rel_trig", waited, DIV);
        repeat (3) @(negedge clk);
        // back-to-back samples; 1000 mm sits exactly on the clamp value
        echo_pulse(5832, 1000);
        trig_cycle(2 * PERIOD_US * DIV, waited, t2);
        check("period", t2 - t1, PERIOD_US * DIV);
        echo_pulse(1166, 199);
        trig_cycle(2 * PERIOD_US * DIV, waited, t3);
        check("period2", t3 - t2, PERIOD_US * DIV);
        echo_pulse(2916, 500);

        // Async reset while trigger is high
        do_reset();
        trig_cycle(10 * DIV, waited, t1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("trig_reset_low", int'(trigger), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("trig_async_drop", int'(trigger), 0);
        clear_hist();

        // No echo: timeout substitute after ECHO_WAIT_US
        do_reset();
        trig_cycle(10 * DIV, waited, t1);
        push_exp(MAX_MM, 1'b1);
        repeat (WAIT_US * DIV + XLAT) @(negedge clk);
        check("to_early", int'(source_data_valid), 0);
        @(negedge clk);
        check("to_strobe", int'(source_data_valid), 1);

        // Clamp 1011 -> 1000, then reset mid-MEASURE on the next trigger
        do_reset();
        trig_cycle(10 * DIV, waited, t1);
        echo_pulse(5900, 1000);
        trig_cycle(2 * PERIOD_US * DIV, waited, t2);
        repeat (100 * DIV) @(negedge clk);
        echo = 1'b1;
        repeat (500 * DIV) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_trigger", int'(trigger), 0);
        check("mid_data", int'(source_data), 0);
        check("mid_valid", int'(source_data_valid), 0);
        check("mid_timeout", int'(source_timeout), 0);
        echo = 1'b0;
        clear_hist();
        repeat (3) @(negedge clk);
        s = n_strobe;
        reset = 1'b0;
        trig_cycle(10 * DIV, waited, t1);
        check("mid_rel_trig", waited, DIV);
        check("mid_no_strobe", n_strobe, s);

        // Shortest echo: 1 us -> 0 mm
        do_reset();
        trig_cycle(10 * DIV, waited, t1);
        echo_pulse(1, 0);

        // Echo stuck high: forced timeout, late fall ignored
        do_reset();
        trig_cycle(10 * DIV, waited, t1);
        repeat (100 * DIV) @(negedge clk);
        echo = 1'b1;
        push_exp(MAX_MM, 1'b1);
        s = n_strobe;
        repeat (EMAX_US * DIV - 10) @(negedge clk);
        check("stuck_early", n_strobe, s);
        waited = 0;
        while (n_strobe == s && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("stuck_strobe", n_strobe, s + 1);
        echo = 1'b0;
        repeat (30) @(negedge clk);
        check("late_fall", n_strobe, s + 1);

        do_reset();
        check("drain", exp_q.size(), 0);
        check("strobes", n_strobe, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
